ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Two-master arbiter sharing one req/gnt/rvalid RAM data port between the ibex data
//  port (m0) and the uart_to_mem loader (m1). It picks a winner round-robin and forwards
//  that master's request to the RAM. It tracks outstanding transactions in an ID FIFO
//  and routes each rvalid/rdata back to the master that issued the request.
// PARAMETERS
//  ADDR_W     12  address width (word RAM byte address, as on RAM ports)
//  DATA_W     32  data width; BE width = DATA_W/8
//  MAX_OUTST  2   max accepted-but-unanswered transactions (power of 2, >=1)
// PORTS
//  clk_i          in   1        clock
//  rst_i          in   1        asynchronous reset, active-high
//  mX_req_i       in   1        X=0 ibex, X=1 uart; request, held until mX_gnt_o
//  mX_addr_i      in   ADDR_W   address
//  mX_we_i        in   1        1=write
//  mX_be_i        in   DATA_W/8 byte enables
//  mX_wdata_i     in   DATA_W   write data
//  mX_gnt_o       out  1        request accepted this cycle
//  mX_rvalid_o    out  1        response valid for master X
//  mX_rdata_o     out  DATA_W   read data (mem_rdata_i broadcast; qualify with rvalid)
//  mem_req_o      out  1        request to RAM
//  mem_addr_o/we_o/be_o/wdata_o out  -  muxed request fields of the selected master
//  mem_gnt_i      in   1        RAM accepted request
//  mem_rvalid_i   in   1        RAM response valid
//  mem_rdata_i    in   DATA_W   RAM read data
//  outst_o        out  clog2(MAX_OUTST+1)  outstanding transaction count
//  err_o          out  1        sticky: rvalid received with empty ID FIFO
// BEHAVIOUR
//  - Reset: outst_o=0, err_o=0, ID FIFO empty, lock clear, rr pointer favours m1.
//    All gnt/rvalid/mem_req outputs read 0 while rst_i is high.
//  - Slot free (can_issue) = outst<MAX_OUTST OR (outst==MAX_OUTST AND mem_rvalid_i).
//    A pop in the same cycle frees a slot.
//  - Selection, combinational: if lock set, sel=locked master. Else if one master
//    requests, sel=it. If both request, sel=master not last granted (rr pointer).
//  - mem_req_o = can_issue & mX_req_i(sel). mem_* fields = sel master fields (0 when idle).
//  - mX_gnt_o = mem_req_o & mem_gnt_i & (sel==X). Grant is zero-latency pass-through.
//  - Lock: set when mem_req_o=1 and mem_gnt_i=0; holds sel until the grant, so the RAM
//    sees a stable request. Cleared on grant.
//  - On grant: push sel into ID FIFO; rr pointer := sel.
//  - Response: on mem_rvalid_i with FIFO non-empty, pop head H and pulse mH_rvalid_o
//    in the same cycle. rvalid with FIFO empty: dropped, err_o:=1 until reset.
//  - Push+pop in the same cycle: count unchanged, order preserved. Count never exceeds
//    MAX_OUTST.
//  - Reset asserted mid-transaction: FIFO, lock and count clear immediately.
//    Late RAM rvalids after reset set err_o. Integrators reset RAM and arbiter together.
//  - Writes also produce rvalid (RAM convention) and are tracked identically.
// TESTING
//  1 m0 alone reads addr 0x010, gnt same cycle, rvalid next -> m0_gnt_o=1 @T;
//    m0_rvalid_o=1 @T+1; m1 outputs 0.
//  2 m0,m1 both req continuously, RAM always grants -> grants alternate m1,m0,m1,m0
//    from reset; rvalids route to the same sequence.
//  3 m1 req, RAM holds gnt=0 3 cycles while m0 raises req -> mem_addr_o stays m1's
//    for all 4 cycles; m1 granted; m0 granted next.
//  4 MAX_OUTST=2, RAM grants but delays rvalid -> 2 grants, then mem_req_o=0 and
//    outst_o=2. An rvalid cycle allows a third grant the same cycle; outst_o stays 2.
//  5 rvalid pulse with empty FIFO -> no mX_rvalid_o, err_o=1 until rst_i.
//  6 assert rst_i with outst_o=1 -> outst_o=0, gnt/rvalid outputs 0 asynchronously;
//    normal arbitration resumes after release.

Source files
------------

// File: rtl/ram_port_if.sv
// Single req/gnt/rvalid RAM data port.
//   master modport : the requester side (drives req/addr/we/be/wdata, receives gnt/rvalid/rdata)
//   slave modport  : the responder side (receives request fields, drives gnt/rvalid/rdata)
interface ram_port_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                  req;
  logic [ADDR_W-1:0]     addr;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-master round-robin arbiter in front of one req/gnt/rvalid RAM port.
// m0 is the ibex data port, m1 the uart_to_mem loader. Accepted transactions
// are remembered in an ID FIFO so each rvalid/rdata is routed back to the
// master that issued it.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   m0, m1       : master-facing ports (slave modport)
//   mem          : RAM-facing port (master modport)
//   outst_o      : accepted-but-unanswered transaction count
//   err_o        : sticky, rvalid seen while nothing was outstanding
module ram_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  ram_port_if.slave                        m0,
  ram_port_if.slave                        m1,
  ram_port_if.master                       mem,
  output logic [$clog2(MAX_OUTST+1)-1:0]   outst_o,
  output logic                             err_o
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_e;

  lock_state_e            state_q, state_d;
  logic                   lock_sel_q, lock_sel_d;
  logic                   rr_last_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [MAX_OUTST-1:0]   id_mem;
  logic                   err_q;

  logic fifo_empty, can_issue, sel, sel_req, issue, grant, pop, head;

  // Wrapping pointer advance; MAX_OUTST need not fill the pointer range.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTST - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign fifo_empty = (cnt_q == '0);
  // A response popping this cycle frees its slot for a same-cycle issue.
  assign can_issue  = (cnt_q < CNT_W'(MAX_OUTST)) ||
                      ((cnt_q == CNT_W'(MAX_OUTST)) && mem.rvalid);

  // Winner: locked master while a request waits for gnt, else the sole
  // requester, else the one not granted last.
  always_comb begin
    sel = 1'b0;
    if (state_q == ST_LOCKED)   sel = lock_sel_q;
    else if (m0.req && m1.req)  sel = ~rr_last_q;
    else if (m1.req)            sel = 1'b1;
    else                        sel = 1'b0;
  end

  assign sel_req = sel ? m1.req : m0.req;
  assign issue   = ~rst_i & can_issue & sel_req;
  assign grant   = issue & mem.gnt;
  assign pop     = ~rst_i & mem.rvalid & ~fifo_empty;
  assign head    = id_mem[rd_ptr_q];

  assign mem.req   = issue;
  assign mem.addr  = issue ? (sel ? m1.addr  : m0.addr)  : '0;
  assign mem.we    = issue ? (sel ? m1.we    : m0.we)    : 1'b0;
  assign mem.be    = issue ? (sel ? m1.be    : m0.be)    : '0;
  assign mem.wdata = issue ? (sel ? m1.wdata : m0.wdata) : '0;

  assign m0.gnt    = grant & ~sel;
  assign m1.gnt    = grant &  sel;
  assign m0.rvalid = pop & ~head;
  assign m1.rvalid = pop &  head;
  assign m0.rdata  = mem.rdata;
  assign m1.rdata  = mem.rdata;

  assign outst_o = cnt_q;
  assign err_o   = err_q;

  // Lock keeps the RAM request stable while the RAM stalls the grant.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    case (state_q)
      ST_OPEN: begin
        if (issue && !mem.gnt) begin
          state_d    = ST_LOCKED;
          lock_sel_d = sel;
        end
      end
      ST_LOCKED: begin
        if (grant) state_d = ST_OPEN;
      end
      default: state_d = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_OPEN;
      lock_sel_q <= 1'b0;
      rr_last_q  <= 1'b0;   // last granted = m0, so m1 wins the first tie
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      if (grant) begin
        rr_last_q <= sel;
        wr_ptr_q  <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (grant && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !grant) cnt_q <= cnt_q - CNT_W'(1);
      if (mem.rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  // ID storage holds no control state; validity is tracked by the pointers.
  // When full with a same-cycle pop, the overwritten entry is the head
  // that is being consumed this cycle.
  always_ff @(posedge clk_i) begin
    if (grant) id_mem[wr_ptr_q] <= sel;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int MAX_OUTST = 2;
  localparam int CNT_W     = $clog2(MAX_OUTST + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
  ram_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
  ram_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();
  logic [CNT_W-1:0] outst;
  logic             err;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .m0     (m0_bus),
    .m1     (m1_bus),
    .mem    (mem_bus),
    .outst_o(outst),
    .err_o  (err)
  );

  // Stimulus state, one entry per master.
  logic              r  [2];
  logic [ADDR_W-1:0] a  [2];
  logic              w  [2];
  logic [BE_W-1:0]   b  [2];
  logic [DATA_W-1:0] wd [2];
  logic              g, rv;
  logic [DATA_W-1:0] rd;

  // Reference model: queue of owners of outstanding transactions.
  int  q[$];
  bit  lk;
  int  lm;
  int  last;
  bit  merr;
  bit  e_g0, e_g1;

  int errors = 0;
  int checks = 0;
  int hist[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    lk = 0; lm = 0; last = 0; merr = 0;
  endtask

  task automatic new_req(input int m);
    r[m]  = 1'b1;
    a[m]  = ADDR_W'($urandom);
    w[m]  = 1'($urandom);
    b[m]  = BE_W'($urandom);
    wd[m] = $urandom;
  endtask

  task automatic apply();
    m0_bus.req = r[0]; m0_bus.addr = a[0]; m0_bus.we = w[0]; m0_bus.be = b[0]; m0_bus.wdata = wd[0];
    m1_bus.req = r[1]; m1_bus.addr = a[1]; m1_bus.we = w[1]; m1_bus.be = b[1]; m1_bus.wdata = wd[1];
    mem_bus.gnt = g; mem_bus.rvalid = rv; mem_bus.rdata = rd;
  endtask

  // One clock cycle: drive, check combinational and registered outputs
  // against the model, then advance the model at the clock edge.
  task automatic cycle(input string tag);
    int s, h;
    bit can, req, pop;
    logic [ADDR_W-1:0] ea;
    logic ew;
    logic [BE_W-1:0] eb;
    logic [DATA_W-1:0] ewd;
    if (rst) model_reset();
    apply();
    #1;
    can = (q.size() < MAX_OUTST) || (q.size() == MAX_OUTST && rv);
    s = -1;
    if (lk)                s = lm;
    else if (r[0] && r[1]) s = 1 - last;
    else if (r[0])         s = 0;
    else if (r[1])         s = 1;
    req = !rst && can && (s >= 0) && r[s];
    ea = '0; ew = 1'b0; eb = '0; ewd = '0;
    if (req) begin ea = a[s]; ew = w[s]; eb = b[s]; ewd = wd[s]; end
    e_g0 = req && g && (s == 0);
    e_g1 = req && g && (s == 1);
    pop  = !rst && rv && (q.size() > 0);
    h    = pop ? q[0] : -1;
    chk({tag, ".mem_req"},   mem_bus.req,      req);
    chk({tag, ".mem_addr"},  mem_bus.addr,     ea);
    chk({tag, ".mem_we"},    mem_bus.we,       ew);
    chk({tag, ".mem_be"},    mem_bus.be,       eb);
    chk({tag, ".mem_wdata"}, mem_bus.wdata,    ewd);
    chk({tag, ".m0_gnt"},    m0_bus.gnt,       e_g0);
    chk({tag, ".m1_gnt"},    m1_bus.gnt,       e_g1);
    chk({tag, ".m0_rvalid"}, m0_bus.rvalid,    (h == 0));
    chk({tag, ".m1_rvalid"}, m1_bus.rvalid,    (h == 1));
    chk({tag, ".m0_rdata"},  m0_bus.rdata,     rd);
    chk({tag, ".m1_rdata"},  m1_bus.rdata,     rd);
    chk({tag, ".outst"},     outst,            q.size());
    chk({tag, ".err"},       err,              merr);
    @(posedge clk);
    if (!rst) begin
      if (rv) begin
        if (q.size() > 0) void'(q.pop_front());
        else merr = 1;
      end
      if (req && g) begin
        q.push_back(s);
        last = s;
        lk = 0;
        r[s] = 1'b0;
      end else if (req) begin
        lk = 1;
        lm = s;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 8 && q.size() > 0; i++) begin
      g = 1'b0; rv = 1'b1; rd = $urandom;
      cycle(tag);
    end
    rv = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      r[m] = 1'b0; a[m] = '0; w[m] = 1'b0; b[m] = '0; wd[m] = '0;
    end
    g = 1'b0; rv = 1'b0; rd = '0;
    model_reset();
    @(negedge clk);

    // Reset: everything idle, including a RAM that pulses gnt/rvalid.
    r[0] = 1'b1; r[1] = 1'b1; g = 1'b1; rv = 1'b1;
    cycle("rst");
    r[0] = 1'b0; r[1] = 1'b0; g = 1'b0; rv = 1'b0;
    cycle("rst2");
    rst = 1'b0;

    // m0 alone reads 0x010, granted same cycle, answered next cycle.
    r[0] = 1'b1; a[0] = 12'h010; w[0] = 1'b0; b[0] = 4'hF; wd[0] = '0; g = 1'b1;
    cycle("t1.req");
    chk("t1.m0_granted", e_g0, 1'b1);
    g = 1'b0; rv = 1'b1; rd = 32'hCAFE_0010;
    cycle("t1.rsp");
    rv = 1'b0;

    // Both request continuously, RAM always grants: alternation from m1.
    for (int i = 0; i < 8; i++) begin
      if (!r[0]) new_req(0);
      if (!r[1]) new_req(1);
      g = 1'b1; rv = (q.size() > 0); rd = $urandom;
      cycle("t2");
      hist.push_back(e_g1 ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) chk("t2.order", hist[i], (i % 2 == 0) ? 1 : 0);
    r[0] = 1'b0; r[1] = 1'b0;
    drain("t2.drain");

    // m1 stalled by RAM for 3 cycles while m0 joins; m1 stays selected.
    new_req(1); a[1] = 12'h3A4; g = 1'b0;
    cycle("t3.s0");
    new_req(0); a[0] = 12'h155;
    cycle("t3.s1");
    cycle("t3.s2");
    g = 1'b1;
    cycle("t3.g1");
    chk("t3.m1_granted", e_g1, 1'b1);
    cycle("t3.g0");
    chk("t3.m0_granted", e_g0, 1'b1);
    drain("t3.drain");

    // Outstanding limit: two grants, stall, then a same-cycle pop allows a third.
    for (int i = 0; i < 3; i++) begin
      if (!r[0]) new_req(0);
      g = 1'b1; rv = 1'b0;
      cycle("t4.fill");
    end
    chk("t4.stalled", e_g0, 1'b0);
    rv = 1'b1; rd = $urandom;
    cycle("t4.swap");
    chk("t4.third_grant", e_g0, 1'b1);
    rv = 1'b0; g = 1'b0;
    cycle("t4.hold");
    drain("t4.drain");

    // rvalid with nothing outstanding: dropped, err sticks.
    g = 1'b0; rv = 1'b1; rd = $urandom;
    cycle("t5.stray");
    rv = 1'b0;
    cycle("t5.err");
    cycle("t5.err2");

    // Reset mid-transaction clears count/err/outputs without a clock edge.
    new_req(0); g = 1'b1;
    cycle("t6.issue");
    new_req(0); new_req(1); g = 1'b1; rv = 1'b0;
    apply();
    #2;
    rst = 1'b1;
    #1;
    chk("t6.async_outst",  outst,          0);
    chk("t6.async_err",    err,            0);
    chk("t6.async_m0_gnt", m0_bus.gnt,     0);
    chk("t6.async_m1_gnt", m1_bus.gnt,     0);
    chk("t6.async_memreq", mem_bus.req,    0);
    @(negedge clk);
    cycle("t6.inrst");
    rst = 1'b0;
    cycle("t6.resume");
    chk("t6.m1_first", e_g1, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) if (!r[m] && ($urandom_range(0, 2) == 0)) new_req(m);
      g  = ($urandom_range(0, 3) != 0);
      rv = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      rd = $urandom;
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
